// File: rtl/ring_decoder_pkg.sv
// Shared types and constants for the ring counter decoder.
// Included by ring_decoder and its testbench.
package ring_decoder_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      LOCKED = 2'd1,
      ERR    = 2'd2
   } state_t;

   localparam int                  ERRCNT_W   = 8;
   localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = 8'd255;

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary index, with a flag for exactly-one-bit-set.
// The index is only meaningful when is_onehot is 1.
module onehot_to_bin #(
   parameter int WIDTH = 4,
   parameter int IW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] din,
   output logic [IW-1:0]    idx,
   output logic             is_onehot
);

   // x & (x-1) clears the lowest set bit, so a zero result means at most one bit was set
   assign is_onehot = (din != '0) && ((din & (din - WIDTH'(1))) == '0);

   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++)
         if (din[i]) idx = idx | IW'(i);
   end

endmodule

// File: rtl/ring_decoder.sv
// Ring counter decoder: checks left-rotation sequence, locks, reports lock losses.
// Define RING_DECODER_ERRCNT_EN to build the saturating err_cnt counter; otherwise err_cnt reads 0.
module ring_decoder #(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 2,
   parameter int BW       = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [WIDTH-1:0] din,
   output logic [BW-1:0] bin,
   output logic          valid,
   output logic          locked,
   output logic          err,
   output logic [7:0]    err_cnt
);
   import ring_decoder_pkg::*;

   localparam logic [3:0]    LOCK_C = 4'(LOCK_CNT);
   localparam logic [BW-1:0] LAST   = BW'(WIDTH - 1);

   state_t           state, state_n;
   logic [WIDTH-1:0] din_q;
   logic [3:0]       cnt, cnt_n;
   logic             valid_n;
   logic [BW-1:0]    idx_d, idx_q, idx_nxt;
   logic             oh_d, oh_q, match;

   onehot_to_bin #(.WIDTH(WIDTH), .IW(BW)) u_dec_d (.din(din),   .idx(idx_d), .is_onehot(oh_d));
   onehot_to_bin #(.WIDTH(WIDTH), .IW(BW)) u_dec_q (.din(din_q), .idx(idx_q), .is_onehot(oh_q));

   // For one-hot codes a left rotate is the same as index+1 modulo WIDTH
   assign idx_nxt = (idx_q == LAST) ? '0 : idx_q + BW'(1);
   assign match   = oh_d && oh_q && (idx_d == idx_nxt);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         HUNT: begin
            if (!match)
               cnt_n = '0;
            else if (cnt + 4'd1 == LOCK_C) begin
               state_n = LOCKED;
               cnt_n   = '0;
            end else
               cnt_n = cnt + 4'd1;
         end
         LOCKED: if (!match) state_n = ERR;
         default: begin
            state_n = HUNT;
            cnt_n   = '0;
         end
      endcase
      valid_n = (state_n == LOCKED) && match;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HUNT;
         din_q <= '0;
         cnt   <= '0;
         bin   <= '0;
         valid <= 1'b0;
      end else begin
         state <= state_n;
         din_q <= din;
         cnt   <= cnt_n;
         valid <= valid_n;
         if (valid_n) bin <= idx_d;
      end
   end

   assign locked = (state == LOCKED);
   assign err    = (state == ERR);

`ifdef RING_DECODER_ERRCNT_EN
   logic [ERRCNT_W-1:0] ecnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ecnt <= '0;
      else if (state_n == ERR && state != ERR && ecnt != ERRCNT_MAX)
         ecnt <= ecnt + ERRCNT_W'(1);
   end

   assign err_cnt = ecnt;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// Scoreboard bench for ring_decoder: directed din rows with hand-computed responses.
// Expected err_cnt follows RING_DECODER_ERRCNT_EN when the bench is built.
module tb_ring_decoder;

   typedef struct {
      int         row;
      logic       valid;
      logic [1:0] bin;
      logic       locked;
      logic       err;
      logic [7:0] err_cnt;
   } exp_t;

   logic       clk, rst;
   logic [3:0] din;
   logic [1:0] bin;
   logic       valid, locked, err;
   logic [7:0] err_cnt;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   row_id = 0;
   int   n_err  = 0;
   logic [1:0] last_bin = '0;

   ring_decoder #(.WIDTH(4), .LOCK_CNT(2)) dut (
      .clk(clk), .rst(rst), .din(din), .bin(bin), .valid(valid),
      .locked(locked), .err(err), .err_cnt(err_cnt)
   );

   initial clk = 1'b1;
   always #10 clk = ~clk;

   task automatic compare(input exp_t e);
      checks++;
      if (valid !== e.valid || bin !== e.bin || locked !== e.locked ||
          err !== e.err || err_cnt !== e.err_cnt) begin
         errors++;
         $display("FAIL row %0d: got valid=%b bin=%0d locked=%b err=%b err_cnt=%0d, expected valid=%b bin=%0d locked=%b err=%b err_cnt=%0d",
                  e.row, valid, bin, locked, err, err_cnt,
                  e.valid, e.bin, e.locked, e.err, e.err_cnt);
      end
   endtask

   function automatic logic [7:0] exp_errcnt();
`ifdef RING_DECODER_ERRCNT_EN
      return (n_err > 255) ? 8'd255 : 8'(n_err);
`else
      return 8'd0;
`endif
   endfunction

   // Drive din shortly after an edge; the expected outputs after the next edge go on the queue
   task automatic step(input logic [3:0] d, input logic v, input logic [1:0] b,
                       input logic l, input logic e);
      exp_t x;
      @(posedge clk);
      #2;
      din = d;
      if (e) n_err++;
      if (v) last_bin = b;
      x.row = row_id++; x.valid = v; x.bin = last_bin; x.locked = l; x.err = e;
      x.err_cnt = exp_errcnt();
      q.push_back(x);
   endtask

   task automatic check_zero(input int tag);
      exp_t z;
      z.row = tag; z.valid = 0; z.bin = 0; z.locked = 0; z.err = 0; z.err_cnt = 0;
      compare(z);
   endtask

   always begin
      @(posedge clk);
      #1;
      if (q.size() > 0) compare(q.pop_front());
   end

   initial begin
      din = 4'b0000;
      rst = 1'b1;
      #30 check_zero(-1);
      #20 rst = 1'b0;

      // lock and steady rotation
      step(4'b0001,0,0,0,0); step(4'b0010,0,0,0,0); step(4'b0100,1,2,1,0);
      step(4'b1000,1,3,1,0); step(4'b0001,1,0,1,0); step(4'b0010,1,1,1,0);
      // jump 0010 -> 1000, then relock
      step(4'b1000,0,0,0,1); step(4'b0001,0,0,0,0); step(4'b0010,0,0,0,0);
      step(4'b0100,1,2,1,0); step(4'b1000,1,3,1,0);
      // stalled counter
      step(4'b0001,1,0,1,0); step(4'b0010,1,1,1,0); step(4'b0100,1,2,1,0);
      step(4'b0100,0,0,0,1); step(4'b0100,0,0,0,0); step(4'b0100,0,0,0,0);
      step(4'b1000,0,0,0,0); step(4'b0001,1,0,1,0);
      // illegal codes in HUNT clear the match counter
      step(4'b0000,0,0,0,1); step(4'b0001,0,0,0,0); step(4'b0010,0,0,0,0);
      step(4'b0110,0,0,0,0); step(4'b0000,0,0,0,0); step(4'b0001,0,0,0,0);
      step(4'b0010,0,0,0,0); step(4'b0110,0,0,0,0); step(4'b1100,0,0,0,0);
      step(4'b1000,0,0,0,0); step(4'b0001,0,0,0,0); step(4'b0010,1,1,1,0);

      // asynchronous reset while locked
      @(posedge clk);
      #5;
      rst = 1'b1;
      din = 4'b0000;
      #1 check_zero(-2);
      @(posedge clk);
      #1 check_zero(-3);
      #4 rst = 1'b0;
      n_err = 0;
      last_bin = '0;
      step(4'b1000,0,0,0,0); step(4'b0001,0,0,0,0); step(4'b0010,1,1,1,0);

      // repeated lock losses for err_cnt saturation
      for (int i = 0; i < 300; i++) begin
         step(4'b0000,0,0,0,1); step(4'b0001,0,0,0,0);
         step(4'b0010,0,0,0,0); step(4'b0100,1,2,1,0);
      end

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #3;
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected responses left, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
